outarb: RTL and testbench
=========================

# outarb

Per-output-port switch allocator for the 5-port wormhole router. One instance sits at each router output. It arbitrates among the five input channels that have routed a packet to this output, round-robin. The grant is held from the head flit until the tail flit has crossed the crossbar, and it drives the crossbar select for this output.

## Interface

Parameters:
- `ROUTERID`, 0, router index (stats/debug only)
- `OPORT`, 0, output port number this instance serves (0..4)

Ports:
- `clk`  in  1  router clock
- `rst_`  in  1  synchronous, active-low reset
- `req`  in  5  bit i = input channel i requests this output (req & port==OPORT, qualified upstream)
- `ivalid`  in  1  flit on this output's crossbar lane this cycle
- `itype`  in  `TYPEW+1  flit type field of that flit (`TYPE_HEAD/BODY/TAIL/HEADTAIL)
- `grt`  out  5  one-hot grant; bit i feeds grt_<OPORT> of input channel i
- `sel`  out  3  binary index of granted input (crossbar mux select); 0 when idle
- `busy`  out  1  output locked to a packet
- `flit_cnt`  out  16  flits forwarded (only with OUTARB_STATS_EN)
- `stall_cnt`  out  16  locked cycles without a flit (only with OUTARB_STATS_EN)

## Operation

- Two states: IDLE, LOCKED. Reset → IDLE, `grt`=0, `sel`=0, `busy`=0, round-robin pointer `last`=4, counters 0.
- IDLE: if `req`≠0, pick the first set bit searching `last+1, last+2, …` mod 5. Register one-hot `grt`, `sel`=index, `last`=index, go LOCKED. If `req`=0, stay IDLE.
- LOCKED: `grt`/`sel` held constant. Leave only when `ivalid` and `itype` ∈ {TAIL, HEADTAIL}. Then next cycle IDLE, `grt`=0, `busy`=0.
- `req` deassertion while LOCKED is ignored; the lock persists until a tail is seen (wormhole integrity).
- A HEAD flit while LOCKED is not a release event. A tail with `ivalid`=0 is ignored.
- `ivalid` in IDLE is a protocol error: ignored, no state change.
- Index arithmetic is mod 5 on a 3-bit value; values 5..7 never occur in `sel`/`last`.

## Timing

- Grant latency: `req` first seen high at cycle t (IDLE) → `grt`, `sel`, `busy` high from t+1.
- Release: tail accepted at cycle u → `grt`=0 at u+1 (IDLE). Earliest next grant is u+2, so there is one mandatory idle cycle between packets on an output.
- All outputs registered; no combinational path from `req`/`ivalid` to `grt`.
- Reset mid-packet: at the next clock edge with `rst_`=0, all state returns to reset values regardless of lock. Any packet in flight is abandoned; flushing input buffers is the input channels' job.

## Configuration

- `OUTARB_STATS_EN` defined: `flit_cnt` increments on every `ivalid`. `stall_cnt` increments on every LOCKED cycle with `ivalid`=0. Both are 16-bit, saturate at 16'hFFFF, and are cleared only by reset. The ports exist.
- Not defined: counters and ports are absent. Arbitration behaviour is identical.

## Structure

- Flit type encodings (`TYPE_*`), `TYPEW`, `PORTW`, and `Enable`/`Disable` come from the shared `define.h`. Add `OUTARB_NPORT` (5) there.
- One sub-module, `rrpick`: combinational 5-way round-robin picker (in `req`, `last`; out one-hot and index). Kept separate so the VC allocator can reuse it.
- The FSM, pointer and optional counters live in `outarb`.

## Test plan

- Single requester: `req`=5'b00100 at t → `grt`=5'b00100, `sel`=2 at t+1. Send HEAD, BODY, TAIL → `grt`=0 the cycle after TAIL.
- Round-robin fairness: `req`=5'b11111 held, 1-flit HEADTAIL packets → grants in order 0,1,2,3,4,0. Each grant lasts 1 cycle, followed by 1 idle cycle.
- Lock hold: grant input 1, drop `req[1]` and raise `req[3]` mid-packet → `grt` stays 5'b00010 until TAIL, then input 3 is granted 2 cycles after TAIL.
- Non-release events: HEAD flit or `itype`=TAIL with `ivalid`=0 while LOCKED → state remains LOCKED.
- Reset mid-packet: LOCKED on input 4, `rst_`=0 for one cycle → next cycle `grt`=0, `busy`=0. With `req`=5'b10001, input 0 wins (pointer back to 4).
- Stats (`OUTARB_STATS_EN`): 3-flit packet with 2 bubble cycles → `flit_cnt`=3, `stall_cnt`=2. Forcing 70000 flits → `flit_cnt`=16'hFFFF.

Source files
------------

// File: rtl/outarb_pkg.sv
// rtl/outarb_pkg.sv - shared flit type encodings, port widths, FSM states and index helpers
package outarb_pkg;

  localparam int TYPEW        = 1;
  localparam int PORTW        = 3;
  localparam int OUTARB_NPORT = 5;

  localparam logic [TYPEW:0] TYPE_HEAD     = 2'b00;
  localparam logic [TYPEW:0] TYPE_BODY     = 2'b01;
  localparam logic [TYPEW:0] TYPE_TAIL     = 2'b10;
  localparam logic [TYPEW:0] TYPE_HEADTAIL = 2'b11;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_LOCKED = 1'b1
  } state_t;

  // (a + b) mod OUTARB_NPORT for a in 0..4 and b in 0..5; one conditional subtract suffices
  function automatic logic [PORTW-1:0] port_add(input logic [PORTW-1:0] a,
                                                input logic [PORTW-1:0] b);
    logic [PORTW:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= (PORTW+1)'(OUTARB_NPORT)) s = s - (PORTW+1)'(OUTARB_NPORT);
    return s[PORTW-1:0];
  endfunction

  // true for flit types that end a packet and so release the output
  function automatic logic is_tail(input logic [TYPEW:0] t);
    logic r;
    r = 1'b0;
    case (t)
      TYPE_TAIL, TYPE_HEADTAIL: r = 1'b1;
      TYPE_HEAD, TYPE_BODY:     r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/outarb_rrpick.sv
// rtl/outarb_rrpick.sv - combinational 5-way round-robin picker, reusable by the VC allocator
module outarb_rrpick
  import outarb_pkg::*;
(
  input  logic [OUTARB_NPORT-1:0] req,
  input  logic [PORTW-1:0]        last,
  output logic [OUTARB_NPORT-1:0] gnt,
  output logic [PORTW-1:0]        idx
);

  logic             found;
  logic [PORTW-1:0] cand;

  // search last+1, last+2, ... mod 5 and take the first requester found
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= OUTARB_NPORT; k++) begin
      cand = port_add(last, PORTW'(k));
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/outarb.sv
// rtl/outarb.sv - per-output wormhole switch allocator; OUTARB_STATS_EN adds flit/stall counters
module outarb
  import outarb_pkg::*;
#(
  parameter int ROUTERID = 0,
  parameter int OPORT    = 0
) (
  input  logic                    clk,
  input  logic                    rst_,
  input  logic [OUTARB_NPORT-1:0] req,
  input  logic                    ivalid,
  input  logic [TYPEW:0]          itype,
  output logic [OUTARB_NPORT-1:0] grt,
  output logic [PORTW-1:0]        sel,
`ifdef OUTARB_STATS_EN
  output logic [15:0]             flit_cnt,
  output logic [15:0]             stall_cnt,
`endif
  output logic                    busy
);

  state_t                  state, state_n;
  logic [OUTARB_NPORT-1:0] grt_n;
  logic [PORTW-1:0]        sel_n;
  logic [PORTW-1:0]        last, last_n;
  logic [OUTARB_NPORT-1:0] pick_gnt;
  logic [PORTW-1:0]        pick_idx;

  // ROUTERID/OPORT identify the instance for debug only
  logic [31:0] unused_cfg;
  assign unused_cfg = 32'(ROUTERID) ^ 32'(OPORT);

  outarb_rrpick u_rrpick (
    .req  (req),
    .last (last),
    .gnt  (pick_gnt),
    .idx  (pick_idx)
  );

  assign busy = (state == S_LOCKED);

  // state, grant, select and round-robin pointer registers
  always_ff @(posedge clk) begin
    if (!rst_) begin
      state <= S_IDLE;
      grt   <= '0;
      sel   <= '0;
      last  <= PORTW'(OUTARB_NPORT - 1);
    end else begin
      state <= state_n;
      grt   <= grt_n;
      sel   <= sel_n;
      last  <= last_n;
    end
  end

  // grant on any request when idle; hold the lock until a tail flit actually crosses
  always_comb begin
    state_n = state;
    grt_n   = grt;
    sel_n   = sel;
    last_n  = last;
    case (state)
      S_IDLE: begin
        if (|req) begin
          state_n = S_LOCKED;
          grt_n   = pick_gnt;
          sel_n   = pick_idx;
          last_n  = pick_idx;
        end
      end
      S_LOCKED: begin
        if (ivalid && is_tail(itype)) begin
          state_n = S_IDLE;
          grt_n   = '0;
          sel_n   = '0;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

`ifdef OUTARB_STATS_EN
  // saturating counters of forwarded flits and of locked cycles spent waiting on a flit
  always_ff @(posedge clk) begin
    if (!rst_) begin
      flit_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (ivalid && (flit_cnt != 16'hFFFF))
        flit_cnt <= flit_cnt + 16'd1;
      if ((state == S_LOCKED) && !ivalid && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
    end
  end
`else
  // no counters in this build; arbitration is unaffected
`endif

endmodule

// File: tb/tb_outarb.sv
// tb/tb_outarb.sv - scoreboard bench for outarb; build with OUTARB_STATS_EN to cover counters
module tb_outarb;
  import outarb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_;
  logic [4:0]  req;
  logic        ivalid;
  logic [1:0]  itype;
  logic [4:0]  grt;
  logic [2:0]  sel;
  logic        busy;
`ifdef OUTARB_STATS_EN
  logic [15:0] flit_cnt;
  logic [15:0] stall_cnt;
`endif

  typedef struct {
    string      tag;
    logic [4:0] grt;
    logic [2:0] sel;
    logic       busy;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  outarb #(.ROUTERID(0), .OPORT(2)) dut (
    .clk       (clk),
    .rst_      (rst_),
    .req       (req),
    .ivalid    (ivalid),
    .itype     (itype),
    .grt       (grt),
    .sel       (sel),
`ifdef OUTARB_STATS_EN
    .flit_cnt  (flit_cnt),
    .stall_cnt (stall_cnt),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // drive one cycle of inputs, queue the outputs expected after the edge, then compare
  task automatic step(input string tag, input logic [4:0] r, input logic v, input logic [1:0] t,
                      input logic [4:0] eg, input logic [2:0] es, input logic eb);
    exp_t e;
    req    = r;
    ivalid = v;
    itype  = t;
    e.tag  = tag;
    e.grt  = eg;
    e.sel  = es;
    e.busy = eb;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check($sformatf("%s.grt", e.tag), 32'(grt), 32'(e.grt));
      check($sformatf("%s.sel", e.tag), 32'(sel), 32'(e.sel));
      check($sformatf("%s.busy", e.tag), 32'(busy), 32'(e.busy));
    end
  endtask

  initial begin
    rst_   = 1'b0;
    req    = '0;
    ivalid = 1'b0;
    itype  = TYPE_BODY;

    // reset state
    step("rst0", 5'b00000, 1'b0, TYPE_BODY, 5'b00000, 3'd0, 1'b0);
    step("rst1", 5'b11111, 1'b1, TYPE_HEAD, 5'b00000, 3'd0, 1'b0);
`ifdef OUTARB_STATS_EN
    check("rst_flit", 32'(flit_cnt), 32'd0);
    check("rst_stall", 32'(stall_cnt), 32'd0);
`endif
    rst_ = 1'b1;

    // single requester, HEAD/BODY/TAIL
    step("single_gnt",  5'b00100, 1'b0, TYPE_BODY, 5'b00100, 3'd2, 1'b1);
    step("single_head", 5'b00000, 1'b1, TYPE_HEAD, 5'b00100, 3'd2, 1'b1);
    step("single_body", 5'b00000, 1'b1, TYPE_BODY, 5'b00100, 3'd2, 1'b1);
    step("single_tail", 5'b00000, 1'b1, TYPE_TAIL, 5'b00000, 3'd0, 1'b0);

    // return the pointer to 4, then all requesting with 1-flit packets
    rst_ = 1'b0;
    step("rst2", 5'b00000, 1'b0, TYPE_BODY, 5'b00000, 3'd0, 1'b0);
    rst_ = 1'b1;
    for (int k = 0; k < 6; k++) begin
      int p;
      p = k % 5;
      step($sformatf("rr_gnt%0d", k), 5'b11111, 1'b0, TYPE_BODY, 5'(1 << p), 3'(p), 1'b1);
      step($sformatf("rr_rel%0d", k), 5'b11111, 1'b1, TYPE_HEADTAIL, 5'b00000, 3'd0, 1'b0);
    end

    // lock hold across req changes and non-release events (pointer now 0)
    step("lock_gnt",   5'b00010, 1'b0, TYPE_BODY, 5'b00010, 3'd1, 1'b1);
    step("lock_head",  5'b01000, 1'b1, TYPE_HEAD, 5'b00010, 3'd1, 1'b1);
    step("lock_bub",   5'b01000, 1'b0, TYPE_BODY, 5'b00010, 3'd1, 1'b1);
    step("lock_tailx", 5'b01000, 1'b0, TYPE_TAIL, 5'b00010, 3'd1, 1'b1);
    step("lock_head2", 5'b01000, 1'b1, TYPE_HEAD, 5'b00010, 3'd1, 1'b1);
    step("lock_tail",  5'b01000, 1'b1, TYPE_TAIL, 5'b00000, 3'd0, 1'b0);
    step("lock_next",  5'b01000, 1'b0, TYPE_BODY, 5'b01000, 3'd3, 1'b1);
    step("lock_rel",   5'b00000, 1'b1, TYPE_TAIL, 5'b00000, 3'd0, 1'b0);

    // stray flit while idle is ignored
    step("idle_flit",  5'b00000, 1'b1, TYPE_TAIL, 5'b00000, 3'd0, 1'b0);

    // reset mid-packet on input 4, pointer returns to 4 so input 0 wins
    step("mid_gnt4",   5'b10000, 1'b0, TYPE_BODY, 5'b10000, 3'd4, 1'b1);
    step("mid_head",   5'b10000, 1'b1, TYPE_HEAD, 5'b10000, 3'd4, 1'b1);
    rst_ = 1'b0;
    step("mid_rst",    5'b10001, 1'b0, TYPE_BODY, 5'b00000, 3'd0, 1'b0);
    rst_ = 1'b1;
    step("mid_gnt0",   5'b10001, 1'b0, TYPE_BODY, 5'b00001, 3'd0, 1'b1);
    step("mid_rel",    5'b10001, 1'b1, TYPE_HEADTAIL, 5'b00000, 3'd0, 1'b0);
    // pointer at 0: search order 1,2,3,4 reaches input 4 first
    step("wrap_gnt4",  5'b10001, 1'b0, TYPE_BODY, 5'b10000, 3'd4, 1'b1);
    step("wrap_rel",   5'b00000, 1'b1, TYPE_TAIL, 5'b00000, 3'd0, 1'b0);

`ifdef OUTARB_STATS_EN
    // 3-flit packet with 2 bubbles
    rst_ = 1'b0;
    step("st_rst",  5'b00000, 1'b0, TYPE_BODY, 5'b00000, 3'd0, 1'b0);
    rst_ = 1'b1;
    step("st_gnt",  5'b00001, 1'b0, TYPE_BODY, 5'b00001, 3'd0, 1'b1);
    step("st_head", 5'b00001, 1'b1, TYPE_HEAD, 5'b00001, 3'd0, 1'b1);
    step("st_bub1", 5'b00001, 1'b0, TYPE_BODY, 5'b00001, 3'd0, 1'b1);
    step("st_body", 5'b00001, 1'b1, TYPE_BODY, 5'b00001, 3'd0, 1'b1);
    step("st_bub2", 5'b00001, 1'b0, TYPE_BODY, 5'b00001, 3'd0, 1'b1);
    step("st_tail", 5'b00000, 1'b1, TYPE_TAIL, 5'b00000, 3'd0, 1'b0);
    check("st_flit3", 32'(flit_cnt), 32'd3);
    check("st_stall2", 32'(stall_cnt), 32'd2);
    // saturation
    req    = 5'b00000;
    ivalid = 1'b1;
    itype  = TYPE_BODY;
    repeat (70000) @(posedge clk);
    #1;
    check("st_flit_sat", 32'(flit_cnt), 32'h0000FFFF);
    check("st_stall_hold", 32'(stall_cnt), 32'd2);
    check("st_sat_busy", 32'(busy), 32'd0);
    ivalid = 1'b0;
`endif

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
